// File: rtl/loader_pkg.sv
// ============================================================================
// Module   : loader_pkg
// Purpose  : Shared states and framing constants for the program loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int INSTR_W    = 32;
  localparam int BYTE_IDX_W = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    ST_RX_LEN0 = 3'd0,
    ST_RX_LEN1 = 3'd1,
    ST_RX_WORD = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RX_CSUM = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } loader_state_t;

  // States in which the host link may transfer a byte.
  function automatic logic accepts_byte(input loader_state_t s);
    return (s == ST_RX_LEN0) || (s == ST_RX_LEN1) ||
           (s == ST_RX_WORD) || (s == ST_RX_CSUM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/word_assembler.sv
// ============================================================================
// Module   : word_assembler
// Purpose  : Packs bytes LSB-first into one instruction word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_assembler
  import loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic [7:0]         i_byte,
  output logic [INSTR_W-1:0] o_word,
  output logic               o_last,
  output logic               o_full
);

  localparam logic [BYTE_IDX_W-1:0] c_LAST_IDX = BYTE_IDX_W'(WORD_BYTES - 1);

  logic [INSTR_W-1:0]    r_word;
  logic [BYTE_IDX_W-1:0] r_idx;
  logic                  r_full;

  // Each new byte enters at the top, so the first byte ends in bits [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (i_shift) begin
      r_word <= {i_byte, r_word[INSTR_W-1:8]};
      r_idx  <= r_idx + 1'b1;
      r_full <= (r_idx == c_LAST_IDX);
    end
  end

  assign o_word = r_word;
  assign o_last = (r_idx == c_LAST_IDX);
  assign o_full = r_full;

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Purpose  : Receives a framed byte image, writes it to instruction memory and
//            releases the CPU once the checksum verifies.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               done,
  output logic               error
);

  localparam int c_LEN_W = LEN_BYTES * 8;

  loader_state_t        r_state;
  loader_state_t        w_state_next;
  logic                 r_byte_ready;
  logic                 r_imem_we;
  logic [ADDR_W-1:0]    r_imem_addr;
  logic                 r_cpu_reset;
  logic                 r_done;
  logic                 r_error;
  logic [7:0]           r_csum;
  logic [c_LEN_W-1:0]   r_len;
  logic [c_LEN_W-1:0]   r_word_cnt;
  logic [c_LEN_W-1:0]   w_word_cnt_inc;
  logic [c_LEN_W-1:0]   w_len_full;
  logic                 w_accept;
  logic                 w_reload;
  logic [INSTR_W-1:0]   w_asm_word;
  logic                 w_asm_last;
  logic                 w_asm_full;

  assign w_accept       = byte_valid & r_byte_ready;
  assign w_reload       = reload & ((r_state == ST_DONE) | (r_state == ST_ERROR));
  assign w_word_cnt_inc = r_word_cnt + 1'b1;
  assign w_len_full     = {byte_data, r_len[7:0]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RX_LEN0: if (w_accept) w_state_next = ST_RX_LEN1;
      ST_RX_LEN1: begin
        if (w_accept) begin
          if (32'(w_len_full) > 32'(MAX_WORDS)) w_state_next = ST_ERROR;
          else if (w_len_full == '0)            w_state_next = ST_RX_CSUM;
          else                                  w_state_next = ST_RX_WORD;
        end
      end
      ST_RX_WORD: if (w_accept && w_asm_last) w_state_next = ST_WRITE;
      ST_WRITE:   w_state_next = (w_word_cnt_inc == r_len) ? ST_RX_CSUM : ST_RX_WORD;
      ST_RX_CSUM: begin
        if (w_accept) w_state_next = (byte_data == r_csum) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: if (w_reload) w_state_next = ST_RX_LEN0;
      default:    w_state_next = ST_RX_LEN0;
    endcase
  end

  // The assembler stays full only during WRITE, which is when it is emptied.
  word_assembler u_word_assembler (
    .clk     (clk),
    .rst     (reset),
    .i_clear (w_reload | w_asm_full),
    .i_shift (w_accept && (r_state == ST_RX_WORD)),
    .i_byte  (byte_data),
    .o_word  (w_asm_word),
    .o_last  (w_asm_last),
    .o_full  (w_asm_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RX_LEN0;
      r_byte_ready <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= BASE_ADDR;
      r_cpu_reset  <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_csum       <= '0;
      r_len        <= '0;
      r_word_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_byte_ready <= w_reload ? 1'b0 : accepts_byte(w_state_next);
      r_imem_we    <= (w_state_next == ST_WRITE);
      if (w_reload) begin
        r_imem_addr <= BASE_ADDR;
        r_cpu_reset <= 1'b1;
        r_done      <= 1'b0;
        r_error     <= 1'b0;
        r_csum      <= '0;
        r_len       <= '0;
        r_word_cnt  <= '0;
      end else begin
        if (w_accept && (r_state != ST_RX_CSUM)) r_csum <= r_csum ^ byte_data;
        if (w_accept && (r_state == ST_RX_LEN0)) r_len[7:0]  <= byte_data;
        if (w_accept && (r_state == ST_RX_LEN1)) r_len[15:8] <= byte_data;
        if (r_state == ST_WRITE) begin
          r_imem_addr <= r_imem_addr + ADDR_W'(WORD_BYTES);
          r_word_cnt  <= w_word_cnt_inc;
        end
        if ((r_state == ST_RX_CSUM) && (w_state_next == ST_DONE)) begin
          r_done      <= 1'b1;
          r_cpu_reset <= 1'b0;
        end
        if (w_state_next == ST_ERROR) r_error <= 1'b1;
      end
    end
  end

  assign byte_ready = r_byte_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = w_asm_word;
  assign cpu_reset  = r_cpu_reset;
  assign done       = r_done;
  assign error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Directed and randomized frames checked against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        reload;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  program_loader #(
    .ADDR_W    (64),
    .BASE_ADDR (64'd0),
    .MAX_WORDS (1024)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          ready_during_we = 0;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      if (byte_ready) ready_during_we++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Entered and left at a falling edge; optional idle gaps toggle byte_valid.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_data  = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (byte_ready) begin
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_end();
    for (int t = 0; t < 100; t++) begin
      if (done || error) return;
      @(negedge clk);
    end
    chk("completion_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("reload_done", 64'(done), 64'd0);
    chk("reload_error", 64'(error), 64'd0);
    @(negedge clk);
    chk("reload_byte_ready", 64'(byte_ready), 64'd1);
  endtask

  // Model: LEN, words LSB-first, XOR checksum; writes land at consecutive words.
  task automatic run_frame(input logic [31:0] words[$], input logic [7:0] csum_flip,
                           input int max_gap);
    logic [7:0]  frame[$];
    logic [7:0]  csum;
    logic [15:0] len;
    bit          bad;
    len = 16'(words.size());
    frame.push_back(len[7:0]);
    frame.push_back(len[15:8]);
    foreach (words[i]) for (int k = 0; k < 4; k++) frame.push_back(8'(words[i] >> (8 * k)));
    csum = 8'h00;
    foreach (frame[i]) csum ^= frame[i];
    frame.push_back(csum ^ csum_flip);
    bad = (csum_flip != 8'h00);
    wr_addr_q.delete();
    wr_data_q.delete();
    ready_during_we = 0;
    foreach (frame[i]) send_byte(frame[i], max_gap);
    byte_valid = 1'b0;
    wait_end();
    chk("write_count", 64'(wr_addr_q.size()), 64'(words.size()));
    for (int i = 0; i < words.size() && i < wr_addr_q.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wr_addr_q[i], 64'(i * 4));
      chk($sformatf("wr_data[%0d]", i), 64'(wr_data_q[i]), 64'(words[i]));
    end
    chk("done", 64'(done), 64'(!bad));
    chk("error", 64'(error), 64'(bad));
    chk("cpu_reset", 64'(cpu_reset), 64'(bad));
    chk("byte_ready_end", 64'(byte_ready), 64'd0);
    chk("ready_during_write", 64'(ready_during_we), 64'd0);
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_byte_ready"}, 64'(byte_ready), 64'd0);
    chk({pfx, "_imem_we"}, 64'(imem_we), 64'd0);
    chk({pfx, "_imem_addr"}, imem_addr, 64'd0);
    chk({pfx, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    chk({pfx, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    chk({pfx, "_done"}, 64'(done), 64'd0);
    chk({pfx, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    logic [31:0] basic[$];
    logic [31:0] none[$];
    logic [31:0] rnd[$];
    int          n;
    logic [7:0]  flip;

    basic = '{32'h12345678, 32'hDEADBEEF};
    reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; reload = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_values("por");
    reset = 1'b0;
    @(negedge clk);

    // Basic load: 02 00 78 56 34 12 EF BE AD DE 28
    run_frame(basic, 8'h00, 0);
    do_reload();

    // Bad checksum 0x29
    run_frame(basic, 8'h01, 0);
    do_reload();

    // Empty image
    run_frame(none, 8'h00, 0);
    do_reload();

    // Oversize length 1025
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    byte_valid = 1'b0;
    chk("oversize_error", 64'(error), 64'd1);
    chk("oversize_byte_ready", 64'(byte_ready), 64'd0);
    repeat (3) @(negedge clk);
    chk("oversize_writes", 64'(wr_addr_q.size()), 64'd0);
    chk("oversize_cpu_reset", 64'(cpu_reset), 64'd1);
    do_reload();

    // Backpressure on the basic frame, then random frames with random gaps
    run_frame(basic, 8'h00, 3);
    do_reload();
    for (int it = 0; it < 6; it++) begin
      rnd.delete();
      n = int'($urandom_range(0, 5));
      for (int i = 0; i < n; i++) rnd.push_back($urandom);
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(rnd, flip, 2);
      do_reload();
    end

    // Reset mid-word: LEN plus two instruction bytes, then async reset
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    reset = 1'b1;
    #1;
    chk_reset_values("midreset");
    byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame(basic, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
